// File: rtl/rf_pkg.sv
// Shared types and constants for the register-bank write-port controller.
package rf_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    localparam logic [AW-1:0] REG_ZERO = '0;

    // One pending writeback: live is cleared when a younger ALU write to the
    // same register supersedes it, so it drains without touching the bank.
    typedef struct packed {
        logic            live;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rf_pend_fifo.sv
// Pending-load FIFO: holds load results that lost arbitration to the ALU,
// supports killing entries by destination register, and offers two lookup
// ports that each return the youngest live entry for a register.
module rf_pend_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  wb_entry_t       push_entry,
    input  logic            pop,
    input  logic            kill,
    input  logic [AW-1:0]   kill_rd,
    input  logic [AW-1:0]   look_rd1,
    input  logic [AW-1:0]   look_rd2,
    output logic            hit1,
    output logic [XLEN-1:0] data1,
    output logic            hit2,
    output logic [XLEN-1:0] data2,
    output wb_entry_t       head,
    output logic [CW-1:0]   count
);

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   idx;

    // Storage, pointers and occupancy; popped slots are marked dead so that
    // unoccupied slots can never produce a lookup hit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill && mem[i].rd == kill_rd) begin
                    mem[i].live <= 1'b0;
                end
            end
            if (pop) begin
                mem[rd_ptr].live <= 1'b0;
                rd_ptr           <= rd_ptr + 1'b1;
            end
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Scan oldest to youngest so the last live match found is the youngest.
    always_comb begin
        hit1  = 1'b0;
        data1 = '0;
        hit2  = 1'b0;
        data2 = '0;
        idx   = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (mem[idx].live && mem[idx].rd == look_rd1) begin
                hit1  = 1'b1;
                data1 = mem[idx].data;
            end
            if (mem[idx].live && mem[idx].rd == look_rd2) begin
                hit2  = 1'b1;
                data2 = mem[idx].data;
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/rf_write_port_ctrl.sv
// Write-port initiator for Reg_Bank: merges single-cycle ALU results and
// variable-latency load results onto WE3/A3/WD3 through one staging register,
// parks colliding loads in a pending FIFO, and forwards not-yet-committed
// writes onto the decode read data.
module rf_write_port_ctrl #(
    parameter int XLEN  = rf_pkg::XLEN,
    parameter int AW    = rf_pkg::AW,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [AW-1:0]   ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            WE3,
    output logic [AW-1:0]   A3,
    output logic [XLEN-1:0] WD3,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic [CW-1:0]   pend_cnt,
    output logic            idle
);

    import rf_pkg::*;

    logic            alu_wr;
    logic            ld_push;
    logic            fifo_pop;
    logic            fifo_empty;
    wb_entry_t       push_entry;
    wb_entry_t       head;
    wb_entry_t       wp;
    wb_entry_t       wp_next;
    logic            hit1;
    logic            hit2;
    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;

    assign alu_wr     = alu_valid && (alu_rd != REG_ZERO);
    assign fifo_empty = (pend_cnt == '0);
    assign ld_ready   = (pend_cnt != CW'(DEPTH));
    assign ld_push    = ld_valid && ld_ready && (ld_rd != REG_ZERO);
    assign fifo_pop   = !alu_wr && !fifo_empty;

    // A load arriving alongside an ALU write to the same register is older
    // than that write, so it enters the FIFO already dead.
    assign push_entry = '{live: !(alu_wr && alu_rd == ld_rd), rd: ld_rd, data: ld_data};

    rf_pend_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (ld_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .kill       (alu_wr),
        .kill_rd    (alu_rd),
        .look_rd1   (ra1),
        .look_rd2   (ra2),
        .hit1       (hit1),
        .data1      (fwd1),
        .hit2       (hit2),
        .data2      (fwd2),
        .head       (head),
        .count      (pend_cnt)
    );

    // Arbitration: the ALU always wins; the FIFO head drains otherwise, and a
    // dead head is popped without producing a write.
    always_comb begin
        wp_next = '0;
        if (alu_wr) begin
            wp_next.live = 1'b1;
            wp_next.rd   = alu_rd;
            wp_next.data = alu_data;
        end else if (fifo_pop && head.live) begin
            wp_next = head;
        end
    end

    // Write staging register feeding the bank port directly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wp <= '0;
        end else begin
            wp <= wp_next;
        end
    end

    assign WE3  = wp.live;
    assign A3   = wp.rd;
    assign WD3  = wp.data;
    assign idle = fifo_empty && !wp.live;

    // Read port 1 forwarding: x0, then youngest pending load, then staged write.
    always_comb begin
        rd1 = rf_rd1;
        if (ra1 == REG_ZERO) begin
            rd1 = '0;
        end else if (hit1) begin
            rd1 = fwd1;
        end else if (wp.live && wp.rd == ra1) begin
            rd1 = wp.data;
        end
    end

    // Read port 2 forwarding, same priority as port 1.
    always_comb begin
        rd2 = rf_rd2;
        if (ra2 == REG_ZERO) begin
            rd2 = '0;
        end else if (hit2) begin
            rd2 = fwd2;
        end else if (wp.live && wp.rd == ra2) begin
            rd2 = wp.data;
        end
    end

endmodule

// File: tb/tb_rf_write_port_ctrl.sv
// Testbench for rf_write_port_ctrl: directed scenarios with a scoreboard of
// expected bank writes and a behavioural Reg_Bank fed by WE3/A3/WD3.
module tb_rf_write_port_ctrl;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    typedef struct {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            alu_valid = 1'b0;
    logic [AW-1:0]   alu_rd = '0;
    logic [XLEN-1:0] alu_data = '0;
    logic            ld_valid = 1'b0;
    logic [AW-1:0]   ld_rd = '0;
    logic [XLEN-1:0] ld_data = '0;
    logic [AW-1:0]   ra1 = '0;
    logic [AW-1:0]   ra2 = '0;
    logic            ld_ready;
    logic            WE3;
    logic [AW-1:0]   A3;
    logic [XLEN-1:0] WD3;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [CW-1:0]   pend_cnt;
    logic            idle;

    logic [XLEN-1:0] bank [32] = '{default: '0};
    wr_t             exp_q [$];
    wr_t             mon_e;
    logic            mon_en = 1'b0;
    int              total = 0;
    int              passed = 0;

    // Expected per-cycle values for the load-backpressure scenario.
    logic            t2_rdy [12] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    int              t2_cnt [12] = '{0, 1, 2, 3, 4, 4, 3, 3, 2, 1, 0, 0};
    logic [XLEN-1:0] t2_rd2 [12] = '{32'h0,  32'h11, 32'h22, 32'h33, 32'h44, 32'h44,
                                     32'h44, 32'h55, 32'h55, 32'h55, 32'h55, 32'h55};

    rf_write_port_ctrl #(
        .XLEN  (XLEN),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .WE3       (WE3),
        .A3        (A3),
        .WD3       (WD3),
        .ra1       (ra1),
        .ra2       (ra2),
        .rf_rd1    (rf_rd1),
        .rf_rd2    (rf_rd2),
        .rd1       (rd1),
        .rd2       (rd2),
        .pend_cnt  (pend_cnt),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    // The raw x0 read is deliberately nonzero so the controller's own zeroing is visible.
    assign rf_rd1 = (ra1 == '0) ? 32'hBAD0_BAD0 : bank[ra1];
    assign rf_rd2 = (ra2 == '0) ? 32'hBAD0_BAD0 : bank[ra2];

    // Behavioural Reg_Bank: commits at the end of the cycle WE3 is high.
    always @(posedge clk) begin
        if (WE3 === 1'b1) begin
            bank[A3] <= WD3;
        end
    end

    task automatic checkOutput(input string name, input logic [XLEN-1:0] act,
                               input logic [XLEN-1:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic expectWrite(input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
        wr_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs just after the edge, then return at the falling edge.
    task automatic applyStimulus(input logic r, input logic av, input logic [AW-1:0] ard,
                                 input logic [XLEN-1:0] ad, input logic lv,
                                 input logic [AW-1:0] lrd, input logic [XLEN-1:0] ldd);
        @(posedge clk);
        #1;
        rst       = r;
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
        ld_valid  = lv;
        ld_rd     = lrd;
        ld_data   = ldd;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Scoreboard monitor: every bank write must match the next expected write.
    always @(negedge clk) begin
        if (mon_en && WE3 === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("[TB] FAIL unexpected_write: got A3=%0d WD3=0x%h, expected no write",
                         A3, WD3);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("write_addr", XLEN'(A3), XLEN'(mon_e.rd));
                checkOutput("write_data", WD3, mon_e.data);
            end
        end
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset and reset-state checks
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        applyStimulus(1'b0, 1'b1, 5'd6, 32'h1, 1'b1, 5'd6, 32'h2);
        idleCycle();
        mon_en = 1'b1;
        checkOutput("reset_we3", XLEN'(WE3), 32'd0);
        checkOutput("reset_a3", XLEN'(A3), 32'd0);
        checkOutput("reset_wd3", WD3, 32'd0);
        checkOutput("reset_pend_cnt", XLEN'(pend_cnt), 32'd0);
        checkOutput("reset_idle", XLEN'(idle), 32'd1);
        checkOutput("reset_ld_ready", XLEN'(ld_ready), 32'd1);

        // Single ALU write with forwarding before commit
        ra1 = 5'd3;
        expectWrite(5'd3, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, '0, '0);
        idleCycle();
        checkOutput("t1_we3", XLEN'(WE3), 32'd1);
        checkOutput("t1_rd1_fwd", rd1, 32'hDEADBEEF);
        idleCycle();
        checkOutput("t1_idle", XLEN'(idle), 32'd1);
        checkOutput("t1_rd1_bank", rd1, 32'hDEADBEEF);

        // ALU busy while loads back up, then drain in order
        ra2 = 5'd5;
        for (int k = 0; k < 5; k++) expectWrite(5'd7, 32'h700 + k);
        for (int k = 1; k <= 5; k++) expectWrite(5'd5, 32'h11 * k);
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, (k < 5), 5'd7, 32'h700 + k,
                          (k < 7), 5'd5, (k < 5) ? 32'h11 * (k + 1) : 32'h55);
            checkOutput($sformatf("t2_ld_ready_c%0d", k), XLEN'(ld_ready), XLEN'(t2_rdy[k]));
            checkOutput($sformatf("t2_pend_cnt_c%0d", k), XLEN'(pend_cnt), XLEN'(t2_cnt[k]));
            checkOutput($sformatf("t2_rd2_c%0d", k), rd2, t2_rd2[k]);
        end
        checkOutput("t2_bank_r5", bank[5], 32'h55);

        // WAW kill of a queued load by a later ALU write
        ra1 = 5'd9;
        expectWrite(5'd8, 32'h800);
        expectWrite(5'd9, 32'hBBBB);
        applyStimulus(1'b1, 1'b1, 5'd8, 32'h800, 1'b1, 5'd9, 32'hAAAA);
        checkOutput("t3_ld_ready", XLEN'(ld_ready), 32'd1);
        applyStimulus(1'b1, 1'b1, 5'd9, 32'hBBBB, 1'b0, '0, '0);
        checkOutput("t3_pend_cnt_queued", XLEN'(pend_cnt), 32'd1);
        checkOutput("t3_rd1_pending_load", rd1, 32'hAAAA);
        idleCycle();
        checkOutput("t3_pend_cnt_dead", XLEN'(pend_cnt), 32'd1);
        checkOutput("t3_rd1_after_kill", rd1, 32'hBBBB);
        idleCycle();
        checkOutput("t3_pend_cnt_drained", XLEN'(pend_cnt), 32'd0);
        checkOutput("t3_we3_dead_pop", XLEN'(WE3), 32'd0);
        checkOutput("t3_rd1_bank", rd1, 32'hBBBB);
        checkOutput("t3_idle", XLEN'(idle), 32'd1);
        checkOutput("t3_bank_r9", bank[9], 32'hBBBB);

        // Same-cycle ALU and load to one register: load is dead on arrival
        ra1 = 5'd4;
        expectWrite(5'd4, 32'h1);
        applyStimulus(1'b1, 1'b1, 5'd4, 32'h1, 1'b1, 5'd4, 32'h2);
        checkOutput("t4_ld_ready", XLEN'(ld_ready), 32'd1);
        idleCycle();
        checkOutput("t4_pend_cnt", XLEN'(pend_cnt), 32'd1);
        checkOutput("t4_rd1", rd1, 32'h1);
        idleCycle();
        checkOutput("t4_pend_cnt_drained", XLEN'(pend_cnt), 32'd0);
        checkOutput("t4_we3", XLEN'(WE3), 32'd0);
        checkOutput("t4_bank_r4", bank[4], 32'h1);
        checkOutput("t4_rd1_bank", rd1, 32'h1);

        // Writes to x0 are accepted and dropped
        ra1 = 5'd0;
        applyStimulus(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'h1234);
        checkOutput("t5_ld_ready", XLEN'(ld_ready), 32'd1);
        checkOutput("t5_rd1_x0", rd1, 32'd0);
        idleCycle();
        checkOutput("t5_we3", XLEN'(WE3), 32'd0);
        checkOutput("t5_pend_cnt", XLEN'(pend_cnt), 32'd0);
        checkOutput("t5_rd1_x0_next", rd1, 32'd0);
        checkOutput("t5_idle", XLEN'(idle), 32'd1);

        // Reset with three live loads pending discards them
        ra1 = 5'd11;
        for (int k = 0; k < 3; k++) expectWrite(5'd10, 32'hA00 + k);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 5'd10, 32'hA00 + k, 1'b1, 5'd11, 32'hB1 + k);
        end
        applyStimulus(1'b0, 1'b1, 5'd12, 32'hC00, 1'b1, 5'd13, 32'hD00);
        checkOutput("t6_pend_cnt_before", XLEN'(pend_cnt), 32'd3);
        checkOutput("t6_rd1_pending", rd1, 32'hB3);
        idleCycle();
        checkOutput("t6_pend_cnt", XLEN'(pend_cnt), 32'd0);
        checkOutput("t6_we3", XLEN'(WE3), 32'd0);
        checkOutput("t6_idle", XLEN'(idle), 32'd1);
        checkOutput("t6_ld_ready", XLEN'(ld_ready), 32'd1);
        checkOutput("t6_rd1_after_reset", rd1, 32'd0);
        repeat (4) idleCycle();
        checkOutput("t6_bank_r11", bank[11], 32'd0);
        checkOutput("t6_bank_r12", bank[12], 32'd0);
        checkOutput("t6_bank_r13", bank[13], 32'd0);

        checkOutput("scoreboard_drained", XLEN'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rf_write_port_ctrl.md
Name: rf_write_port_ctrl

Overview:
- Initiator side of the register bank's single write port (WE3/A3/WD3). Merges two writeback sources, single-cycle ALU results and variable-latency load results, onto that one port.
- Holds colliding load results in a small FIFO and forwards pending, not-yet-committed writes onto the read data.
- Decode therefore always sees architecturally current values.
- Sits between the execute/memory stages and Reg_Bank.

Parameters:
XLEN, 32, data width; matches Reg_Bank WD3/RD1/RD2
AW, 5, register address width (32 registers, x0 hardwired zero)
DEPTH, 4, load pending-FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-low reset
alu_valid  in  1  ALU result this cycle; always accepted, never stalled
alu_rd  in  AW  ALU destination register
alu_data  in  XLEN  ALU result
ld_valid  in  1  load result offered
ld_ready  out  1  load accepted when ld_valid && ld_ready
ld_rd  in  AW  load destination register
ld_data  in  XLEN  load data
WE3  out  1  to Reg_Bank write enable
A3  out  AW  to Reg_Bank write address
WD3  out  XLEN  to Reg_Bank write data
ra1, ra2  in  AW  decode read addresses (same values driven to Reg_Bank A1/A2)
rf_rd1, rf_rd2  in  XLEN  raw Reg_Bank RD1/RD2
rd1, rd2  out  XLEN  forwarded read data
pend_cnt  out  $clog2(DEPTH)+1  live FIFO occupancy
idle  out  1  FIFO empty and no write staged

Behaviour:
- Reset (rst==0 at an edge): FIFO emptied and all entries invalidated; staged write cleared. WE3=0, A3=0, WD3=0, pend_cnt=0, idle=1. Inputs are ignored during the reset cycle. Reset mid-drain discards pending loads without writing them.
- Write stage register (wp): WE3/A3/WD3 are driven directly from wp, giving one cycle of latency. A source presented in cycle N drives WE3 in cycle N+1, and Reg_Bank commits at the end of N+1.
- Arbitration each cycle:
  - alu_valid with alu_rd!=0: wp <= ALU result.
  - Otherwise, if the FIFO head is live: wp <= head, then pop.
  - Otherwise: wp invalid (WE3=0).
- The ALU always wins. The FIFO drains only in ALU-idle cycles.
- Writes to x0: never enqueued and never raise WE3. They are accepted and dropped; ld_ready is still honoured.
- ld_ready = (pend_cnt != DEPTH). Computed combinationally from occupancy; no same-cycle pop bypass. A load presented while full waits.
- Enqueue: on a load handshake with ld_rd!=0, push {rd, data, live=1}. A push and a pop in the same cycle leave the count unchanged.
- WAW kill:
  - When alu_valid with alu_rd==R, every live FIFO entry with rd==R has its live bit cleared (it is older than the ALU write).
  - A load enqueued in the same cycle to R is pushed with live=0; the ALU write is defined as younger.
  - Dead entries pop without asserting WE3 and consume a drain slot.
  - pend_cnt counts all occupied slots, dead or live.
- Forwarding is combinational, per read port p (priority high to low):
  1. ra_p==0: output 0.
  2. Youngest live FIFO entry with rd==ra_p.
  3. wp valid and A3==ra_p: WD3.
  4. Otherwise rf_rd_p.
- Same-cycle ALU/load inputs are not forwarded; decode sees them from the next cycle.
- FIFO pointers are DEPTH-modulo with wrap-around. The full/empty distinction uses the count.
- idle = (pend_cnt==0) && !wp valid.

Decomposition:
- Package rf_pkg holds:
  - XLEN and AW constants.
  - typedef wb_entry_t {logic live; logic [AW-1:0] rd; logic [XLEN-1:0] data;}.
  - Constant REG_ZERO = 0.
- One sub-module: rf_pend_fifo. It is a DEPTH-entry FIFO of wb_entry_t with a kill-by-address input and two parallel lookup ports, each returning the youngest live match.
- Arbitration and wp stay in the top level.

Test Plan:
1. Reset, then alu_valid rd=3 data=0xDEADBEEF for one cycle -> next cycle WE3=1, A3=3, WD3=0xDEADBEEF; with ra1=3, rd1=0xDEADBEEF before the bank commits; idle=1 two cycles later.
2. alu_valid held every cycle (rd=7) while loads to rd=5 (0x11,0x22,0x33,0x44,0x55) are offered -> four accepted, ld_ready=0 with pend_cnt=4; after ALU stops they drain in order one per cycle; final R5=0x55 and rd2 (ra2=5) tracks the youngest pending value throughout.
3. Load rd=9 data=0xAAAA enqueued behind ALU traffic, then ALU writes rd=9 data=0xBBBB -> the entry is killed, WE3 never writes 0xAAAA to R9, R9=0xBBBB, and rd1 (ra1=9) shows 0xBBBB from the cycle after the ALU write.
4. Same cycle: ALU rd=4 data=0x1 and load rd=4 data=0x2 -> load accepted but dead; R4=0x1.
5. ALU rd=0 data=0xFFFFFFFF, and load rd=0 -> WE3 stays 0, pend_cnt unchanged, rd1 with ra1=0 is 0.
6. FIFO holding 3 live loads, rst=0 for one cycle -> pend_cnt=0, WE3=0, idle=1; no further writes to the bank.
